// File: rtl/bus_arbiter_pkg.sv
// Shared types and sizing helpers for the round-robin tristate bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_t;

  // Ceiling log2, constant-evaluable for sizing owner indices and counters.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/enable bundle between the bus masters and the arbiter.
interface bus_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned OWNER_WIDTH = 2
);
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] grant;
  logic [NUM_MASTERS-1:0] bus_en;
  logic                   bus_busy;
  logic [OWNER_WIDTH-1:0] owner;

  modport master (output req, input grant, bus_en, bus_busy, owner);
  modport slave  (input req, output grant, bus_en, bus_busy, owner);
endinterface

// File: rtl/bus_arbiter_rr_priority_select.sv
// Round-robin winner selection: rotate requests so the search starts just
// after the previous owner, take the lowest set bit, map back to an index.
module rr_priority_select #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned OWNER_WIDTH = 2
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [OWNER_WIDTH-1:0] last_owner_i,
  output logic [OWNER_WIDTH-1:0] winner_o,
  output logic                   valid_o
);

  logic [2*NUM_MASTERS-1:0] req_dbl;
  logic [NUM_MASTERS-1:0]   req_rot;
  int unsigned              start;
  int unsigned              offset;

  // Rotate, fixed-priority find-first, convert back to absolute index.
  always_comb begin
    req_dbl = {req_i, req_i};
    start   = (32'(last_owner_i) + 32'd1) % NUM_MASTERS;
    req_rot = req_dbl[start +: NUM_MASTERS];
    offset  = 0;
    // Scan downward so the lowest set rotated bit is the last one written.
    for (int unsigned i = NUM_MASTERS; i > 0; i--) begin
      if (req_rot[i-1]) offset = i - 1;
    end
    winner_o = OWNER_WIDTH'((start + offset) % NUM_MASTERS);
    valid_o  = |req_i;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter driving the enables of a shared tristate bus:
// at most one enable high, a turnaround gap between owners, and bounded
// ownership while others are waiting.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned MAX_HOLD    = 8,
  parameter int unsigned TURNAROUND  = 1,
  parameter int unsigned OWNER_WIDTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.slave  bus
);

  localparam int unsigned HOLD_W = cnt_width(MAX_HOLD);
  localparam int unsigned TURN_W = cnt_width(TURNAROUND);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURNAROUND - 1);

  arb_state_t             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [OWNER_WIDTH-1:0] owner_q, owner_d;
  logic                   busy_q, busy_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [TURN_W-1:0]      turn_q, turn_d;
  logic [OWNER_WIDTH-1:0] last_q, last_d;

  logic [OWNER_WIDTH-1:0] winner;
  logic                   win_valid;
  logic                   owner_req;
  logic                   others_req;

  rr_priority_select #(
    .NUM_MASTERS (NUM_MASTERS),
    .OWNER_WIDTH (OWNER_WIDTH)
  ) u_sel (
    .req_i        (bus.req),
    .last_owner_i (last_q),
    .winner_o     (winner),
    .valid_o      (win_valid)
  );

  assign owner_req  = |(bus.req & grant_q);
  assign others_req = |(bus.req & ~grant_q);

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    busy_d  = busy_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d = ST_GRANT;
          grant_d = NUM_MASTERS'(1) << winner;
          owner_d = winner;
          busy_d  = 1'b1;
          hold_d  = '0;
          last_d  = winner;
        end
      end
      ST_GRANT: begin
        if (!owner_req || (hold_q == HOLD_LAST && others_req)) begin
          state_d = ST_TURN;
          grant_d = '0;
          owner_d = '0;
          busy_d  = 1'b0;
          turn_d  = '0;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_TURN: begin
        if (turn_q == TURN_LAST) begin
          if (win_valid) begin
            state_d = ST_GRANT;
            grant_d = NUM_MASTERS'(1) << winner;
            owner_d = winner;
            busy_d  = 1'b1;
            hold_d  = '0;
            last_d  = winner;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          turn_d = turn_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        owner_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
      turn_q  <= '0;
      last_q  <= OWNER_WIDTH'(NUM_MASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      last_q  <= last_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.bus_en   = grant_q;
  assign bus.bus_busy = busy_q;
  assign bus.owner    = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with NUM_MASTERS=4, MAX_HOLD=4, TURNAROUND=1.
module tb_bus_arbiter;

  logic clk;
  logic rst;

  bus_arbiter_if #(.NUM_MASTERS(4), .OWNER_WIDTH(2)) bif ();

  bus_arbiter #(
    .NUM_MASTERS (4),
    .MAX_HOLD    (4),
    .TURNAROUND  (1),
    .OWNER_WIDTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] owner;
  } vec_t;

  vec_t       tbl[$];
  int         checks;
  int         errors;
  logic [3:0] prev_en;

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                     input logic [1:0] o, input int n);
    vec_t v;
    v.rst = r; v.req = rq; v.grant = g; v.owner = o;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, check at the next falling edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] eg,
                      input logic [1:0] eo, input string nm);
    rst     = r;
    bif.req = rq;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bif.grant !== eg) begin
      errors++;
      $display("FAIL %s grant: got %b expected %b", nm, bif.grant, eg);
    end
    checks++;
    if (bif.bus_en !== eg) begin
      errors++;
      $display("FAIL %s bus_en: got %b expected %b", nm, bif.bus_en, eg);
    end
    checks++;
    if (bif.bus_busy !== (|eg)) begin
      errors++;
      $display("FAIL %s bus_busy: got %b expected %b", nm, bif.bus_busy, |eg);
    end
    checks++;
    if (bif.owner !== eo) begin
      errors++;
      $display("FAIL %s owner: got %0d expected %0d", nm, bif.owner, eo);
    end
    checks++;
    if ($countones(bif.bus_en) > 1) begin
      errors++;
      $display("FAIL %s onehot: bus_en %b has more than one bit set", nm, bif.bus_en);
    end
    checks++;
    if (prev_en != 4'b0000 && bif.bus_en != 4'b0000 && prev_en != bif.bus_en) begin
      errors++;
      $display("FAIL %s no_gap: bus_en went %b -> %b without idle cycle", nm, prev_en, bif.bus_en);
    end
    prev_en = bif.bus_en;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    prev_en = 4'b0000;
    rst     = 1'b1;
    bif.req = 4'b0000;

    // Reset, then round-robin with all requesting, then single request.
    add(1'b1, 4'b1111, 4'b0000, 2'd0, 2);
    add(1'b0, 4'b1111, 4'b0001, 2'd0, 4);
    add(1'b0, 4'b1111, 4'b0000, 2'd0, 1);
    add(1'b0, 4'b1111, 4'b0010, 2'd1, 4);
    add(1'b0, 4'b1111, 4'b0000, 2'd0, 1);
    add(1'b0, 4'b1111, 4'b0100, 2'd2, 4);
    add(1'b0, 4'b1111, 4'b0000, 2'd0, 1);
    add(1'b0, 4'b1111, 4'b1000, 2'd3, 4);
    add(1'b0, 4'b1111, 4'b0000, 2'd0, 1);
    add(1'b0, 4'b1111, 4'b0001, 2'd0, 1);
    add(1'b0, 4'b0000, 4'b0000, 2'd0, 3);
    add(1'b0, 4'b0100, 4'b0100, 2'd2, 3);
    add(1'b0, 4'b0000, 4'b0000, 2'd0, 3);
    add(1'b0, 4'b0010, 4'b0010, 2'd1, 1);
    add(1'b0, 4'b0000, 4'b0000, 2'd0, 2);

    @(negedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].grant, tbl[i].owner, $sformatf("vec%0d", i));
    end

    // Lone requester keeps the bus past the hold limit; saturated hold forces
    // immediate preemption once another master asks.
    for (int i = 0; i < 12; i++) step(1'b0, 4'b0001, 4'b0001, 2'd0, $sformatf("lone%0d", i));
    step(1'b0, 4'b0011, 4'b0000, 2'd0, "lone_preempt");
    step(1'b0, 4'b0011, 4'b0010, 2'd1, "lone_next");
    step(1'b0, 4'b0000, 4'b0000, 2'd0, "lone_rel");
    step(1'b0, 4'b0000, 4'b0000, 2'd0, "lone_idle");

    // Handover race: owner 0 drops while master 3 raises in the same cycle.
    step(1'b0, 4'b0001, 4'b0001, 2'd0, "race_g0");
    step(1'b0, 4'b0001, 4'b0001, 2'd0, "race_g1");
    step(1'b0, 4'b1000, 4'b0000, 2'd0, "race_gap");
    step(1'b0, 4'b1000, 4'b1000, 2'd3, "race_new");
    step(1'b0, 4'b0000, 4'b0000, 2'd0, "race_rel");
    step(1'b0, 4'b0000, 4'b0000, 2'd0, "race_idle");

    // Reset mid-grant restores the round-robin pointer.
    step(1'b0, 4'b0100, 4'b0100, 2'd2, "mrst_g");
    step(1'b0, 4'b1111, 4'b0100, 2'd2, "mrst_hold");
    step(1'b1, 4'b1111, 4'b0000, 2'd0, "mrst_rst");
    step(1'b0, 4'b1111, 4'b0001, 2'd0, "mrst_first");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
